// File: rtl/ssd_mux_ctrl.sv
// Time-multiplexed seven-segment display driver.
// Holds a shadow copy of the digit values and the dp/blank masks, and scans one
// digit per slot. Each slot opens with a dead time in which all anodes are off.
// Optional leading-zero suppression is applied. All pins come straight from flops.
module ssd_mux_ctrl #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYCLES    = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IDX_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  load_i,
    input  logic [4*N_DIGITS-1:0] value_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   blank_i,
    input  logic                  lz_en_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic [IDX_W-1:0]      digit_idx_o
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD     = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [N_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

    logic [4*N_DIGITS-1:0] val_q;
    logic [N_DIGITS-1:0]   dpm_q;
    logic [N_DIGITS-1:0]   blank_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [IDX_W-1:0]      idx_out_q;

    logic [3:0]            nib;
    logic                  blank_sel, dp_sel, lz_sel, blanked;
    logic [N_DIGITS-1:0]   lz_mask;
    logic                  lz_run;
    logic [6:0]            seg_raw, seg_act;
    logic [N_DIGITS-1:0]   an_hot;

    // Slot counter and digit index advance only while scanning is enabled
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (enable_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Select the current digit, work out blanking, and decode it into pin levels
    always_comb begin
        nib       = '0;
        blank_sel = 1'b0;
        dp_sel    = 1'b0;
        lz_sel    = 1'b0;
        an_hot    = '0;
        lz_mask   = '0;
        lz_run    = 1'b1;
        // lz_mask[k] is set when nibbles k..N_DIGITS-1 are all zero
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            lz_run = lz_run & (val_q[4*(N_DIGITS-1-i) +: 4] == 4'h0);
            lz_mask[N_DIGITS-1-i] = lz_run;
        end
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib       = val_q[4*i +: 4];
                blank_sel = blank_q[i];
                dp_sel    = dpm_q[i];
                lz_sel    = lz_mask[i];
                an_hot[i] = 1'b1;
            end
        end
        blanked = blank_sel | (lz_en_i & lz_sel & (idx_q != '0));

        case (nib)
            4'h0: seg_raw = 7'h7E;
            4'h1: seg_raw = 7'h30;
            4'h2: seg_raw = 7'h6D;
            4'h3: seg_raw = 7'h79;
            4'h4: seg_raw = 7'h33;
            4'h5: seg_raw = 7'h5B;
            4'h6: seg_raw = 7'h5F;
            4'h7: seg_raw = 7'h70;
            4'h8: seg_raw = 7'h7F;
            4'h9: seg_raw = 7'h7B;
            4'hA: seg_raw = 7'h77;
            4'hB: seg_raw = 7'h1F;
            4'hC: seg_raw = 7'h4E;
            4'hD: seg_raw = 7'h3D;
            4'hE: seg_raw = 7'h4F;
            default: seg_raw = 7'h47;
        endcase
        seg_act = blanked ? 7'h00 : seg_raw;

        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (enable_i) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
            dp_d  = (SEG_ACTIVE_LOW != 0) ? ~(dp_sel & ~blanked) : (dp_sel & ~blanked);
            if (cnt_q >= DEAD) begin
                an_d = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
            end
        end
    end

    // Shadow register, scan state and registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q     <= '0;
            dpm_q     <= '0;
            blank_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
            an_q      <= AN_OFF;
            idx_out_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            idx_out_q <= idx_q;
            if (load_i) begin
                val_q   <= value_i;
                dpm_q   <= dp_i;
                blank_q <= blank_i;
            end
        end
    end

    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign an_o        = an_q;
    assign digit_idx_o = idx_out_q;

endmodule

// File: doc/ssd_mux_ctrl.md
Name: ssd_mux_ctrl

Overview:
Time-multiplexed driver for an N-digit common-anode/common-cathode seven-segment display. It latches an N-nibble hex value plus per-digit decimal-point and blank masks into a shadow register. It scans the digits at a programmable refresh rate, with an anti-ghosting dead time between digits and optional leading-zero suppression. It sits between the peripheral's register bank and the board pins, and replaces the single-digit combinational decoder.

Parameters:
N_DIGITS, 4, number of digits scanned (1..16)
REFRESH_DIV, 50000, clock cycles each digit is shown, including dead time (>= DEAD_CYCLES+2)
DEAD_CYCLES, 8, cycles at the start of each digit slot during which all anodes are off (0 allowed)
SEG_ACTIVE_LOW, 1, 1: seg_o/dp_o are inverted at the output
AN_ACTIVE_LOW, 1, 1: an_o is inverted at the output

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable_i  in  1  1: scan runs; 0: all anodes inactive, scan counter held
load_i  in  1  1-cycle strobe: capture value_i/dp_i/blank_i into the shadow register
value_i  in  4*N_DIGITS  nibble k = digit k; digit 0 is rightmost (least significant)
dp_i  in  N_DIGITS  decimal-point enable per digit
blank_i  in  N_DIGITS  force digit off per digit
lz_en_i  in  1  leading-zero suppression enable (sampled live)
seg_o  out  7  segments {a,b,c,d,e,f,g}; seg_o[6]=a
dp_o  out  1  decimal-point segment
an_o  out  N_DIGITS  digit anodes, one-hot active
digit_idx_o  out  clog2(N_DIGITS) (min 1)  index of the digit currently in its slot

Behaviour:
- Reset (sync, rst=1 at posedge): the shadow register clears to 0, the slot counter and digit index go to 0, and all outputs go to their inactive levels. Inactive means an_o all off, seg_o all off, dp_o off, where "off" honours the *_ACTIVE_LOW parameters. digit_idx_o=0. Reset mid-scan or mid-load aborts immediately; no partial load survives.
- Shadow load: on a posedge with load_i=1, the shadow register takes value_i/dp_i/blank_i, and the new data is displayed from the next clock onward. A load that coincides with rst is ignored.
- Slot counter: counts 0..REFRESH_DIV-1 while enable_i=1. On wrap, digit_idx advances (idx+1, N_DIGITS-1 -> 0). With N_DIGITS=1 the index stays 0.
- Dead time: while the slot counter is < DEAD_CYCLES, an_o is inactive. Otherwise an_o has a single active bit at position digit_idx.
- enable_i=0: counter and index are held, and an_o, seg_o and dp_o are inactive from the next cycle. Re-enabling resumes from the held count.
- Decode (active-high, before polarity): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
- Digit k is blanked (seg off, dp off, anode still driven per slot) when either condition holds:
  - blank_i shadow bit k=1, or
  - lz_en_i=1 AND nibbles k..N_DIGITS-1 are all zero AND k!=0. Digit 0 is never suppressed.
- dp_o = shadow dp[k] unless digit k is blanked.
- Latency: seg_o, dp_o, an_o and digit_idx_o are all registered, with exactly one cycle from counter/index state to pins. an_o and seg_o always change on the same edge, so the display never shows a wrong digit/segment pairing.

Test Plan:
- Reset/idle: N_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, active-low both. Hold rst 3 cycles -> an_o=4'b1111, seg_o=7'h7F, dp_o=1, digit_idx_o=0. Release with enable_i=0 -> outputs unchanged.
- Scan order/timing: load value_i=16'h1234, enable_i=1. Per 4-cycle slot: 1 cycle an_o=1111, then 3 cycles of an_o=1110 with seg_o=~7'h33 ("4"), then 1101/"3", 1011/"2", 0111/"1", then wrap to digit 0.
- Full decode: load 16'h0000..16'hFFFF, stepping one nibble at a time on digit 0 (blank others) -> seg_o matches all 16 table entries, inverted.
- Leading zeros: value 16'h0040, lz_en_i=1 -> digits 3,2 blank, digit 1="4", digit 0="0". Value 16'h0000 -> only digit 0 lit, showing "0". With lz_en_i=0 -> all four show "0".
- DP/blank masks: dp_i=4'b0101, blank_i=4'b0100 -> dp_o active on digit 0 only; digit 2 has seg_o and dp_o off while an_o bit 2 is still active in its slot.
- Mid-operation events: rst asserted during digit 2's slot -> next cycle all outputs inactive and idx=0. load_i while digit 1 is lit -> digit 1 segments change on the very next cycle. enable_i toggled 0 then 1 -> scan resumes at the held slot count.
